// File: rtl/boton_pulsos.sv
// Purpose : synchronise and debounce the two raw push-buttons and turn each accepted
//           press into a single-cycle Aumenta / Disminuye step for the position counter.
// Latency : DEB_MAX+3 edges from the first edge sampling a clean raw 1 to the pulse;
//           there is no backpressure, and each pulse must be consumed in its cycle.
// Ports   : CLK, Res (sync, active-low), BtnArriba / BtnAbajo (raw, async),
//           Aumenta / Disminuye (registered pulses), Estable {abajo, arriba} (debounced).
// Option  : define BOTON_AUTOREPEAT_EN to add hold-to-repeat (REP_DELAY, REP_RATE).
//           Without the macro, each accepted press gives exactly one pulse.
// Index 0 of the internal vectors is arriba and index 1 is abajo, matching Estable.
module boton_pulsos #(
  parameter int CNT_W     = 16,
  parameter int DEB_MAX   = 50000
`ifdef BOTON_AUTOREPEAT_EN
  ,
  parameter int REP_DELAY = 25000,
  parameter int REP_RATE  = 10000
`endif
) (
  input  logic       CLK,
  input  logic       Res,
  input  logic       BtnArriba,
  input  logic       BtnAbajo,
  output logic       Aumenta,
  output logic       Disminuye,
  output logic [1:0] Estable
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_MAX - 1);

  logic [1:0]       w_raw;
  logic [1:0]       r_sync0;
  logic [1:0]       r_sync1;
  logic [CNT_W-1:0] r_deb_cnt [2];
  logic [1:0]       r_est;
  logic [1:0]       r_est_d;
  logic             r_aum;
  logic             r_dis;

  logic [1:0]       w_diff;
  logic [1:0]       w_flip;
  logic [1:0]       w_press;
  logic [1:0]       w_rep_fire;
  logic             w_aum_nxt;
  logic             w_dis_nxt;

  assign w_raw = {BtnAbajo, BtnArriba};

  // The debounced level only changes once the synchronised level has disagreed with
  // it for DEB_MAX consecutive cycles; any single agreeing cycle restarts the count.
  always_comb begin
    w_diff = r_sync1 ^ r_est;
    w_flip = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_flip[i] = w_diff[i] && (r_deb_cnt[i] == DEB_LAST);
    end
  end

  // Rising edge of the debounced level, seen the cycle after Estable changes.
  assign w_press = r_est & ~r_est_d;

  // A new press only counts if the other button is not stable-high in that cycle;
  // this also suppresses both pulses when the two rise together.
  assign w_aum_nxt = (w_press[0] & ~r_est[1]) | w_rep_fire[0];
  assign w_dis_nxt = (w_press[1] & ~r_est[0]) | w_rep_fire[1];

  always_ff @(posedge CLK) begin
    if (!Res) begin
      r_sync0      <= 2'b00;
      r_sync1      <= 2'b00;
      r_deb_cnt[0] <= '0;
      r_deb_cnt[1] <= '0;
      r_est        <= 2'b00;
      r_est_d      <= 2'b00;
      r_aum        <= 1'b0;
      r_dis        <= 1'b0;
    end else begin
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
      r_est   <= r_est ^ w_flip;
      r_est_d <= r_est;
      for (int i = 0; i < 2; i++) begin
        if (!w_diff[i] || w_flip[i]) begin
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + CNT_W'(1);
        end
      end
      r_aum <= w_aum_nxt;
      r_dis <= w_dis_nxt;
    end
  end

`ifdef BOTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_C = CNT_W'(REP_DELAY);
  localparam logic [CNT_W-1:0] REP_RATE_C  = CNT_W'(REP_RATE);

  logic [CNT_W-1:0] r_rep_cnt [2];
  logic [1:0]       r_rep_phase;
  logic [1:0]       w_solo;

  // The repeat counter only runs while its button is the only one stable-high, so
  // releasing it, or the other button becoming stable-high, stops repeats at once.
  assign w_solo = {r_est == 2'b10, r_est == 2'b01};

  // The counter starts at 0 in the cycle Estable rises. That puts the first repeat
  // REP_DELAY edges after the initial pulse, and later repeats every REP_RATE edges.
  always_comb begin
    w_rep_fire = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_rep_fire[i] = w_solo[i] &&
        (r_rep_cnt[i] == (r_rep_phase[i] ? REP_RATE_C : REP_DELAY_C));
    end
  end

  always_ff @(posedge CLK) begin
    if (!Res) begin
      r_rep_cnt[0] <= '0;
      r_rep_cnt[1] <= '0;
      r_rep_phase  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!w_solo[i]) begin
          r_rep_cnt[i]   <= '0;
          r_rep_phase[i] <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_rep_cnt[i]   <= CNT_W'(1);
          r_rep_phase[i] <= 1'b1;
        end else begin
          r_rep_cnt[i]   <= r_rep_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign w_rep_fire = 2'b00;
`endif

  assign Aumenta   = r_aum;
  assign Disminuye = r_dis;
  assign Estable   = r_est;

endmodule

// File: tb/tb_boton_pulsos.sv
// Bench for boton_pulsos with DEB_MAX=4, REP_DELAY=8 and REP_RATE=3.
// Each expected pulse is queued with its cycle when the stimulus is driven.
// The negedge monitor pops and compares an entry for every pulse the DUT produces.
module tb_boton_pulsos;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       res;
  logic       btn_arr;
  logic       btn_aba;
  logic       aumenta;
  logic       disminuye;
  logic [1:0] estable;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    bit dis;
    int at;
  } exp_t;
  exp_t sb_q[$];

  boton_pulsos #(
    .CNT_W    (16),
    .DEB_MAX  (DEB)
`ifdef BOTON_AUTOREPEAT_EN
    ,
    .REP_DELAY(8),
    .REP_RATE (3)
`endif
  ) dut (
    .CLK      (clk),
    .Res      (res),
    .BtnArriba(btn_arr),
    .BtnAbajo (btn_aba),
    .Aumenta  (aumenta),
    .Disminuye(disminuye),
    .Estable  (estable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sb_push(input bit dis, input int at);
    exp_t e;
    e.dis = dis;
    e.at  = at;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: entries that have gone overdue are misses, and any pulse
  // with an empty queue is unexpected.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
      check_val("missed_pulse", 0, sb_q[0].at);
      void'(sb_q.pop_front());
    end
    if (aumenta || disminuye) begin
      check_val("mutex", longint'(aumenta & disminuye), 0);
      if (sb_q.size() == 0) begin
        check_val("unexpected_pulse", {disminuye, aumenta}, 0);
      end else begin
        check_val("pulse_kind", {disminuye, aumenta}, sb_q[0].dis ? 2 : 1);
        check_val("pulse_cycle", cyc, sb_q[0].at);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    res     = 1'b0;
    btn_arr = 1'b1;
    btn_aba = 1'b1;

    // Reset with both buttons held: everything stays clear.
    repeat (3) begin
      @(negedge clk);
      check_val("rst_aum", aumenta, 0);
      check_val("rst_dis", disminuye, 0);
      check_val("rst_est", estable, 0);
    end
    // Release reset with arriba still held: it counts as a new press.
    c = cyc; res = 1'b1; btn_aba = 1'b0;
    sb_push(0, c + DEB + 3);
    tick(5); check_val("rst_est_pre", estable, 0);
    tick(1); check_val("rst_est_set", estable, 1);
    tick(1); btn_arr = 1'b0;
    tick(8); check_val("rst_est_rel", estable, 0);
    check_val("rst_sb_empty", sb_q.size(), 0);

    // Clean press and release.
    tick(3);
    c = cyc; btn_arr = 1'b1;
    sb_push(0, c + DEB + 3);
    tick(5); check_val("clean_est_pre", estable, 0);
    tick(1); check_val("clean_est_set", estable, 1);
    tick(1); c = cyc; btn_arr = 1'b0;
    tick(5); check_val("clean_est_hold", estable, 1);
    tick(1); check_val("clean_est_clr", estable, 0);
    tick(3); check_val("clean_sb_empty", sb_q.size(), 0);

    // Bounce on abajo, then a steady hold.
    btn_aba = 1'b1; tick(1);
    btn_aba = 1'b0; tick(1);
    btn_aba = 1'b1; tick(1);
    btn_aba = 1'b0; tick(1);
    c = cyc; btn_aba = 1'b1;
    sb_push(1, c + DEB + 3);
    tick(5); check_val("bounce_est_pre", estable, 0);
    tick(1); check_val("bounce_est_set", estable, 2);
    tick(1); btn_aba = 1'b0;
    tick(8); check_val("bounce_est_clr", estable, 0);
    check_val("bounce_sb_empty", sb_q.size(), 0);

    // Glitch one cycle short of DEB_MAX.
    btn_arr = 1'b1; tick(3);
    btn_arr = 1'b0;
    tick(3); check_val("glitch_est_mid", estable, 0);
    tick(7); check_val("glitch_est_end", estable, 0);
    check_val("glitch_sb_empty", sb_q.size(), 0);

    // Simultaneous press, then re-press abajo while arriba is held.
    btn_arr = 1'b1; btn_aba = 1'b1;
    tick(6); check_val("simul_est_both", estable, 3);
    btn_aba = 1'b0;
    tick(6); check_val("simul_est_arr", estable, 1);
    btn_aba = 1'b1;
    tick(6); check_val("simul_est_again", estable, 3);
    btn_arr = 1'b0; btn_aba = 1'b0;
    tick(8); check_val("simul_est_clr", estable, 0);
    check_val("simul_sb_empty", sb_q.size(), 0);

    // Reset in the middle of a debounce discards the partial count.
    tick(2);
    btn_arr = 1'b1;
    tick(4); res = 1'b0;
    tick(1); res = 1'b1; c = cyc;
    sb_push(0, c + DEB + 3);
    tick(5); check_val("midrst_est_pre", estable, 0);
    tick(1); check_val("midrst_est_set", estable, 1);
    tick(1); btn_arr = 1'b0;
    tick(8); check_val("midrst_est_clr", estable, 0);
    check_val("midrst_sb_empty", sb_q.size(), 0);

    // Long hold: auto-repeat pulses when the option is built in.
    tick(2);
    c = cyc; btn_arr = 1'b1;
    sb_push(0, c + 7);
`ifdef BOTON_AUTOREPEAT_EN
    for (int k = c + 15; k <= c + 33; k += 3) sb_push(0, k);
`endif
    tick(6); check_val("hold_est_set", estable, 1);
    tick(23); btn_arr = 1'b0;
    tick(8); check_val("hold_est_clr", estable, 0);
    check_val("hold_sb_empty", sb_q.size(), 0);

    // Long hold with abajo pressed mid-way: repeats stop and abajo never pulses.
    tick(2);
    c = cyc; btn_arr = 1'b1;
    sb_push(0, c + 7);
`ifdef BOTON_AUTOREPEAT_EN
    sb_push(0, c + 15);
    sb_push(0, c + 18);
    sb_push(0, c + 21);
`endif
    tick(16); btn_aba = 1'b1;
    tick(10); check_val("stop_est_both", estable, 3);
    tick(8); btn_arr = 1'b0; btn_aba = 1'b0;
    tick(8); check_val("stop_est_clr", estable, 0);
    check_val("stop_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boton_pulsos.md
Name: boton_pulsos

Overview:
- Conditioning stage directly upstream of the calculator screen position counter.
- Takes the two raw, bouncing, asynchronous push-button inputs (move right / move left), then synchronises and debounces them.
- Emits clean single-cycle Aumenta / Disminuye pulses that the position counter consumes one step per pulse.
- Guarantees at most one of the two pulses is asserted in any cycle.

Parameters:
- CNT_W, 16, width of each debounce counter and each auto-repeat counter.
- DEB_MAX, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz); legal range 2 .. 2^CNT_W-1.
- REP_DELAY, 25000, held cycles before the first auto-repeat pulse (used only with the optional feature).
- REP_RATE, 10000, cycles between subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- Res  input  1  reset, synchronous, active-low (0 = reset, sampled on CLK rising edge).
- BtnArriba  input  1  raw button, asynchronous, active-high, "increase position".
- BtnAbajo  input  1  raw button, asynchronous, active-high, "decrease position".
- Aumenta  output  1  one-cycle pulse, registered, to the position counter's increase input.
- Disminuye  output  1  one-cycle pulse, registered, to the position counter's decrease input.
- Estable  output  2  debounced button levels, {abajo, arriba}, registered.

Behaviour:
- Reset (Res=0 at an edge):
  - Synchroniser flops, debounced levels, counters and outputs all clear.
  - Aumenta=0, Disminuye=0, Estable=2'b00.
  - Reset mid-debounce discards the partial count.
  - A button held through reset release is seen as a new press; it pulses after the full debounce latency.
- Synchroniser: two flops per button; the sampled level is s_x.
- Debounce (independent per button):
  - While s_x == Estable bit, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - A single cycle of agreement returns the counter to 0 (bounce rejection).
  - When the counter equals DEB_MAX-1 and the levels still differ, the Estable bit flips on the next edge and the counter clears.
  - The counter never wraps; DEB_MAX is bounded by CNT_W.
- Pulse generation, registered from the Estable edges:
  - Aumenta=1 for exactly one cycle, the cycle after Estable[0] goes 0->1, and only if Estable[1]==0 in that same cycle.
  - Disminuye is symmetric.
  - Both rising in the same cycle: neither pulses.
  - One button already held, other pressed: the new press is ignored.
  - Release (1->0) never pulses.
- Latency: a clean raw rising edge held steady produces Aumenta asserted exactly DEB_MAX+3 edges after the first edge that samples the raw 1 (2 sync + DEB_MAX debounce + 1 pulse register).
- Aumenta and Disminuye are never 1 in the same cycle.

Optional Feature:
- Macro: BOTON_AUTOREPEAT_EN.
- Defined:
  - While exactly one Estable bit is high, a per-button repeat counter runs.
  - REP_DELAY cycles after the initial pulse, a further one-cycle pulse on the same output.
  - Then one pulse every REP_RATE cycles until release.
  - The counter clears on release, on reset, or when the other button becomes stable-high; repeating stops immediately in all three cases.
  - Repeat pulses obey the same mutual-exclusion rule.
- Undefined: exactly one pulse per accepted press; repeat counters and REP_* parameters are absent from the RTL.

Test Plan (DEB_MAX=4, REP_DELAY=8, REP_RATE=3 for simulation):
- Reset: hold Res=0 for 3 cycles with both buttons at 1 -> Aumenta=Disminuye=0, Estable=00 throughout; after release, Aumenta pulses once at cycle 7 after release.
- Clean press: BtnArriba 0->1 held -> single Aumenta pulse at edge 7 (DEB_MAX+3); Estable[0]=1 from edge 6; release pulses nothing; Estable[0]=0 at edge 6 after release.
- Bounce: BtnAbajo toggles 1,0,1,0,1 on successive cycles then held at 1 -> no pulse during toggling; one Disminuye pulse 7 edges after the last 0->1.
- Glitch: BtnArriba high for 3 cycles only -> no pulse, Estable stays 00.
- Simultaneous: both buttons rise on the same cycle -> Estable=11 at edge 6, no pulses; press BtnAbajo while BtnArriba held -> no Disminuye.
- Auto-repeat (macro defined): hold BtnArriba 30 cycles -> Aumenta pulses at edges 7, 15, 18, 21, 24, ...; press BtnAbajo mid-hold -> repeats stop. Macro undefined: only the edge-7 pulse.
